// File: rtl/latch_stimulus_checker_if.sv
// Bundle between the latch self-test engine and its surroundings:
// run control/status plus the drive (D/G) and sense (P/Q) lines of the latch.
interface latch_stimulus_checker_if #(
    parameter int ERR_W = 8
);
    logic             start;
    logic             p_in;
    logic             q_in;
    logic             d_out;
    logic             g_out;
    logic             busy;
    logic             done;
    logic             pass;
    logic [ERR_W-1:0] err_count;
    logic [3:0]       fail_step;

    // checker side
    modport master (
        input  start, p_in, q_in,
        output d_out, g_out, busy, done, pass, err_count, fail_step
    );

    // wrapper / latch side
    modport slave (
        output start, p_in, q_in,
        input  d_out, g_out, busy, done, pass, err_count, fail_step
    );
endinterface

// File: rtl/latch_stimulus_checker.sv
// Clocked driver/monitor for a gated D latch: plays a fixed 12-step (G,D)
// pattern, waits SETTLE_CYCLES per step, compares P/Q against an internal
// latch model and reports error count, first failing step and pass/fail.
module latch_stimulus_checker #(
    parameter int SETTLE_CYCLES = 2,
    parameter int ERR_W         = 8
) (
    input logic                      clk,
    input logic                      rst,
    latch_stimulus_checker_if.master bus
);
    typedef enum logic [2:0] {IDLE, DRIVE, SETTLE, CHECK, DONE} state_t;

    // Stimulus pattern, bit k = step k (upper bits unused so a 4-bit index covers it)
    localparam logic [15:0]      TAB_G       = 16'h09F1;
    localparam logic [15:0]      TAB_D       = 16'h035A;
    localparam logic [3:0]       LAST_STEP   = 4'd11;
    localparam logic [3:0]       NO_FAIL     = 4'hF;
    localparam logic [3:0]       SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
    localparam logic [ERR_W-1:0] ERR_MAX     = '1;

    state_t           state;
    state_t           state_nxt;
    logic [3:0]       step;
    logic [3:0]       settle_cnt;
    logic [3:0]       fail_step;
    logic [ERR_W-1:0] err_count;
    logic             model;
    logic             drive_d;
    logic             drive_g;
    logic             busy;
    logic             done;
    logic             pass;
    logic             step_bad;

    // Step fails if either rail disagrees with the model (Q must be the complement)
    assign step_bad = (bus.p_in != model) || (bus.q_in != ~model);

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: if (bus.start) state_nxt = DRIVE;
            DRIVE:      state_nxt = (SETTLE_CYCLES == 0) ? CHECK : SETTLE;
            SETTLE:     if (settle_cnt == SETTLE_LAST) state_nxt = CHECK;
            CHECK:      state_nxt = (step == LAST_STEP) ? DONE : DRIVE;
            default:    state_nxt = IDLE;
        endcase
    end

    // Status outputs decoded from state
    always_comb begin
        busy = (state == DRIVE) || (state == SETTLE) || (state == CHECK);
        done = (state == DONE);
        pass = done && (err_count == '0);
    end

    // Datapath: step/settle counters, latch model, drive registers, error tracking
    always_ff @(posedge clk) begin
        if (rst) begin
            step       <= '0;
            settle_cnt <= '0;
            model      <= 1'b0;
            drive_d    <= 1'b0;
            drive_g    <= 1'b0;
            err_count  <= '0;
            fail_step  <= NO_FAIL;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        step      <= '0;
                        err_count <= '0;
                        fail_step <= NO_FAIL;
                    end
                end
                DRIVE: begin
                    drive_d    <= TAB_D[step];
                    drive_g    <= TAB_G[step];
                    // step 0 is transparent, so the model never needs a known start value
                    if (TAB_G[step]) model <= TAB_D[step];
                    settle_cnt <= '0;
                end
                SETTLE: settle_cnt <= settle_cnt + 4'd1;
                CHECK: begin
                    if (step_bad) begin
                        if (err_count != ERR_MAX) err_count <= err_count + ERR_W'(1);
                        if (fail_step == NO_FAIL) fail_step <= step;
                    end
                    if (step != LAST_STEP) step <= step + 4'd1;
                end
                default: ;
            endcase
        end
    end

    assign bus.d_out     = drive_d;
    assign bus.g_out     = drive_g;
    assign bus.busy      = busy;
    assign bus.done      = done;
    assign bus.pass      = pass;
    assign bus.err_count = err_count;
    assign bus.fail_step = fail_step;
endmodule

// File: tb/tb_latch_stimulus_checker.sv
// Scoreboard bench: two checker instances (SETTLE=2/ERR_W=8 and SETTLE=0/ERR_W=2)
// each driving a behavioural latch with a selectable fault.
module tb_latch_stimulus_checker;
    typedef struct {
        int len;
        int err;
        int fs;
        int pss;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;
    exp_t sb_a[$];
    exp_t sb_b[$];
    int   mode_a = 0;   // 0 good, 1 Q stuck 0, 2 ignores G, 3 inverted P
    int   mode_b = 0;
    logic lat_a, lat_b;

    // hand-written pattern, step 0..11
    bit tg[12] = '{1, 0, 0, 0, 1, 1, 1, 1, 1, 0, 0, 1};
    bit td[12] = '{0, 1, 0, 1, 1, 0, 1, 0, 1, 1, 0, 0};

    always #5 clk = ~clk;

    latch_stimulus_checker_if #(.ERR_W(8)) bus_a ();
    latch_stimulus_checker_if #(.ERR_W(2)) bus_b ();

    latch_stimulus_checker #(.SETTLE_CYCLES(2), .ERR_W(8)) dut_a (
        .clk(clk), .rst(rst), .bus(bus_a)
    );
    latch_stimulus_checker #(.SETTLE_CYCLES(0), .ERR_W(2)) dut_b (
        .clk(clk), .rst(rst), .bus(bus_b)
    );

    // behavioural latches under test
    always_latch if (bus_a.g_out) lat_a <= bus_a.d_out;
    always_latch if (bus_b.g_out) lat_b <= bus_b.d_out;

    always_comb begin
        bus_a.p_in = lat_a;
        bus_a.q_in = ~lat_a;
        case (mode_a)
            1: bus_a.q_in = 1'b0;
            2: begin bus_a.p_in = bus_a.d_out; bus_a.q_in = ~bus_a.d_out; end
            3: bus_a.p_in = ~lat_a;
            default: ;
        endcase
    end

    always_comb begin
        bus_b.p_in = lat_b;
        bus_b.q_in = ~lat_b;
        case (mode_b)
            1: bus_b.q_in = 1'b0;
            2: begin bus_b.p_in = bus_b.d_out; bus_b.q_in = ~bus_b.d_out; end
            3: bus_b.p_in = ~lat_b;
            default: ;
        endcase
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // monitor A: run length, per-step drive values, end-of-run result vs scoreboard
    initial begin
        int   len = 0;
        logic busy_q = 1'b0;
        logic done_q = 1'b0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus_a.busy && !busy_q) len = 0;
            if (bus_a.busy) begin
                len++;
                if (len >= 2 && (len - 2) % 4 == 0 && (len - 2) / 4 < 12) begin
                    chk($sformatf("a_g_step%0d", (len - 2) / 4), bus_a.g_out, tg[(len - 2) / 4]);
                    chk($sformatf("a_d_step%0d", (len - 2) / 4), bus_a.d_out, td[(len - 2) / 4]);
                end
            end
            if (bus_a.done && !done_q) begin
                if (sb_a.size() == 0) begin
                    chk("a_unexpected_done", 1, 0);
                end else begin
                    e = sb_a.pop_front();
                    chk("a_run_len",   len,               e.len);
                    chk("a_err_count", bus_a.err_count,   e.err);
                    chk("a_fail_step", bus_a.fail_step,   e.fs);
                    chk("a_pass",      bus_a.pass,        e.pss);
                end
            end
            busy_q = bus_a.busy;
            done_q = bus_a.done;
        end
    end

    // monitor B: same checks with a 2-cycle step
    initial begin
        int   len = 0;
        logic busy_q = 1'b0;
        logic done_q = 1'b0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus_b.busy && !busy_q) len = 0;
            if (bus_b.busy) begin
                len++;
                if (len >= 2 && (len - 2) % 2 == 0 && (len - 2) / 2 < 12) begin
                    chk($sformatf("b_g_step%0d", (len - 2) / 2), bus_b.g_out, tg[(len - 2) / 2]);
                    chk($sformatf("b_d_step%0d", (len - 2) / 2), bus_b.d_out, td[(len - 2) / 2]);
                end
            end
            if (bus_b.done && !done_q) begin
                if (sb_b.size() == 0) begin
                    chk("b_unexpected_done", 1, 0);
                end else begin
                    e = sb_b.pop_front();
                    chk("b_run_len",   len,             e.len);
                    chk("b_err_count", bus_b.err_count, e.err);
                    chk("b_fail_step", bus_b.fail_step, e.fs);
                    chk("b_pass",      bus_b.pass,      e.pss);
                end
            end
            busy_q = bus_b.busy;
            done_q = bus_b.done;
        end
    end

    task automatic pulse_a();
        @(negedge clk) bus_a.start = 1'b1;
        @(negedge clk) bus_a.start = 1'b0;
    endtask

    task automatic pulse_b();
        @(negedge clk) bus_b.start = 1'b1;
        @(negedge clk) bus_b.start = 1'b0;
    endtask

    task automatic wait_done_a();
        int n = 0;
        while (bus_a.done !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("a_done_in_time", bus_a.done, 1);
    endtask

    task automatic wait_done_b();
        int n = 0;
        while (bus_b.done !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("b_done_in_time", bus_b.done, 1);
    endtask

    task automatic chk_reset_a(input string tag);
        chk({tag, "_d"},    bus_a.d_out,     0);
        chk({tag, "_g"},    bus_a.g_out,     0);
        chk({tag, "_busy"}, bus_a.busy,      0);
        chk({tag, "_done"}, bus_a.done,      0);
        chk({tag, "_pass"}, bus_a.pass,      0);
        chk({tag, "_err"},  bus_a.err_count, 0);
        chk({tag, "_fs"},   bus_a.fail_step, 4'hF);
    endtask

    initial begin
        bus_a.start = 1'b0;
        bus_b.start = 1'b0;
        repeat (2) @(negedge clk);
        chk_reset_a("rst_a");
        chk("rst_b_busy", bus_b.busy,      0);
        chk("rst_b_err",  bus_b.err_count, 0);
        chk("rst_b_fs",   bus_b.fail_step, 4'hF);
        rst = 1'b0;

        // good latch, plus start latency
        mode_a = 0;
        sb_a.push_back('{48, 0, 15, 1});
        pulse_a();
        chk("lat_busy_after_start", bus_a.busy,  1);
        chk("lat_g_not_yet",        bus_a.g_out, 0);
        @(negedge clk);
        chk("lat_g_step0",          bus_a.g_out, 1);
        wait_done_a();

        // Q stuck at 0
        mode_a = 1;
        sb_a.push_back('{48, 7, 0, 0});
        pulse_a();
        wait_done_a();

        // latch ignores G: mismatches at steps 1,3,10
        mode_a = 2;
        sb_a.push_back('{48, 3, 1, 0});
        pulse_a();
        wait_done_a();

        // reset during SETTLE of step 5 (no scoreboard entry: aborted run)
        mode_a = 1;
        pulse_a();
        repeat (21) @(posedge clk);
        @(negedge clk);
        chk("mid_busy", bus_a.busy,      1);
        chk("mid_err",  bus_a.err_count, 4);
        chk("mid_g",    bus_a.g_out,     1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_reset_a("mid_rst");
        mode_a = 0;
        sb_a.push_back('{48, 0, 15, 1});
        pulse_a();
        wait_done_a();

        // start while busy is ignored; start in DONE restarts
        mode_a = 1;
        sb_a.push_back('{48, 7, 0, 0});
        pulse_a();
        repeat (10) @(negedge clk);
        pulse_a();
        wait_done_a();
        mode_a = 0;
        sb_a.push_back('{48, 0, 15, 1});
        pulse_a();
        chk("restart_done", bus_a.done,      0);
        chk("restart_busy", bus_a.busy,      1);
        chk("restart_err",  bus_a.err_count, 0);
        chk("restart_fs",   bus_a.fail_step, 4'hF);
        wait_done_a();

        // SETTLE=0, ERR_W=2, inverted P: all 12 fail, counter saturates at 3
        mode_b = 3;
        sb_b.push_back('{24, 3, 0, 0});
        pulse_b();
        wait_done_b();

        repeat (3) @(negedge clk);
        chk("a_sb_drained", sb_a.size(), 0);
        chk("b_sb_drained", sb_b.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
